// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, baud constants and parameter checks
// shared by the uart_tx_gen2 transmitter and its FIFO.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } uart_state_t;

   localparam int DIV_9600_100MHZ = 10416;

   function automatic bit data_bits_ok(input int n);
      return (n >= 5) && (n <= 9);
   endfunction

   function automatic bit stop_bits_ok(input int n);
      return (n == 1) || (n == 2);
   endfunction

   function automatic bit depth_ok(input int d);
      return (d >= 2) && ((d & (d - 1)) == 0);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with wrap-bit pointers.
// Full, empty and count come straight from the pointer flops.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign o_count = r_wptr - r_rptr;
   assign o_full  = (o_count == FULL_CNT);
   assign o_empty = (r_wptr == r_rptr);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2: FIFO-buffered UART transmitter, runtime baud divisor.
// Define UART_TX_PARITY_EN to add the optional parity bit and its ports.
module uart_tx_gen2
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
`ifdef UART_TX_PARITY_EN
   input  logic                        parity_en,
   input  logic                        parity_odd,
`endif
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   if (!(data_bits_ok(DATA_BITS) && stop_bits_ok(STOP_BITS) &&
         depth_ok(FIFO_DEPTH))) begin : g_bad_cfg
      $error("uart_tx_gen2: illegal parameter set");
   end

   localparam int BIT_W = 4;
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   uart_state_t          r_state;
   logic [DIV_W-1:0]     r_baud;
   logic [DIV_W-1:0]     r_div;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_busy;
`ifdef UART_TX_PARITY_EN
   logic                 r_pen;
   logic                 r_par;
`endif

   logic [DATA_BITS-1:0] w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_bit_end;
   logic                 w_last_stop;
   logic                 w_load;
   logic                 w_line;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (tx_valid),
      .i_wdata (tx_data),
      .i_pop   (w_load),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign tx_ready    = !w_full;
   assign tx          = r_tx;
   assign busy        = r_busy;
   assign w_bit_end   = (r_baud == r_div);
   assign w_last_stop = (r_state == S_STOP) && w_bit_end &&
                        (r_bit == LAST_STOP);
   // A queued byte is taken either from idle or right as the last stop ends.
   assign w_load      = !w_empty && ((r_state == S_IDLE) || w_last_stop);

   always_comb begin
      w_line = 1'b1;
      unique case (r_state)
         S_START:  w_line = 1'b0;
         S_DATA:   w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_line = r_par;
`endif
         default:  w_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_pen   <= 1'b0;
         r_par   <= 1'b0;
`endif
      end else begin
         r_tx   <= w_line;
         r_busy <= (r_state != S_IDLE);

         if (w_load || (r_state == S_IDLE) || w_bit_end)
            r_baud <= '0;
         else
            r_baud <= r_baud + DIV_W'(1);

         if (w_load) begin
            r_state <= S_START;
            r_bit   <= '0;
            r_shift <= w_head;
            r_div   <= baud_div;
`ifdef UART_TX_PARITY_EN
            r_pen   <= parity_en;
            r_par   <= parity_odd;
`endif
         end else if (w_bit_end) begin
            unique case (r_state)
               S_IDLE: r_state <= S_IDLE;
               S_START: begin
                  r_state <= S_DATA;
                  r_bit   <= '0;
               end
               S_DATA: begin
                  r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
`ifdef UART_TX_PARITY_EN
                  r_par   <= r_par ^ r_shift[0];
`endif
                  if (r_bit == LAST_DATA) begin
                     r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                     r_state <= r_pen ? S_PARITY : S_STOP;
`else
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit <= r_bit + BIT_W'(1);
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: begin
                  r_state <= S_STOP;
                  r_bit   <= '0;
               end
`endif
               S_STOP: begin
                  if (r_bit == LAST_STOP) begin
                     r_state <= S_IDLE;
                     r_bit   <= '0;
                  end else begin
                     r_bit <= r_bit + BIT_W'(1);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
